// File: rtl/conv_encoder_punct.sv
// K=7 (133/171) convolutional encoder with 802.11a puncturing; first coded bit one cycle after input accept, six zero tail bits appended.
// Backpressure: out_bit_o/out_last_o hold while out_ready_i is low; in_ready_o only in LOAD, never while emitting.
module conv_encoder_punct (
    input  logic       clock1_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [1:0] rate_i,
    input  logic       in_valid_i,
    input  logic       in_bit_i,
    input  logic       in_last_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic       out_bit_o,
    output logic       out_last_o,
    input  logic       out_ready_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT_A, EMIT_B} state_t;

    state_t     state_q, state_d;
    logic [1:0] rate_q, rate_d;     // doubles as the last puncture phase index
    logic [6:1] sr_q, sr_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] tail_q, tail_d;
    logic       last_q, last_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       keep_b_q, keep_b_d;
    logic       enc_en, enc_bit, bit_done, final_bit;

    always_ff @(posedge clock1_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            rate_q   <= 2'd0;
            sr_q     <= '0;
            ph_q     <= 2'd0;
            tail_q   <= 3'd0;
            last_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            keep_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            sr_q     <= sr_d;
            ph_q     <= ph_d;
            tail_q   <= tail_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            keep_b_q <= keep_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        sr_d     = sr_q;
        ph_d     = ph_q;
        tail_d   = tail_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        keep_b_d = keep_b_q;
        enc_en   = 1'b0;
        enc_bit  = 1'b0;
        bit_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rate_d  = (rate_i == 2'd3) ? 2'd0 : rate_i;
                    sr_d    = '0;
                    ph_d    = 2'd0;
                    tail_d  = 3'd0;
                    last_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    enc_en  = 1'b1;
                    enc_bit = in_bit_i;
                    last_d  = in_last_i;
                end
            end
            EMIT_A: begin
                if (out_ready_i) begin
                    if (keep_b_q) state_d = EMIT_B;
                    else          bit_done = 1'b1;
                end
            end
            EMIT_B: begin
                if (out_ready_i) bit_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Decide on the final transfer itself so tail bits follow without a bubble.
        if (bit_done) begin
            if (!last_q) begin
                state_d = LOAD;
            end else if (tail_q != 3'd6) begin
                enc_en  = 1'b1;
                enc_bit = 1'b0;
                tail_d  = tail_q + 3'd1;
            end else begin
                state_d = IDLE;
            end
        end

        if (enc_en) begin
            a_d      = enc_bit ^ sr_q[2] ^ sr_q[3] ^ sr_q[5] ^ sr_q[6];
            b_d      = enc_bit ^ sr_q[1] ^ sr_q[2] ^ sr_q[3] ^ sr_q[6];
            sr_d     = {sr_q[5:1], enc_bit};
            keep_b_d = (ph_q == 2'd0);
            ph_d     = (ph_q == rate_q) ? 2'd0 : ph_q + 2'd1;
            state_d  = (ph_q != 2'd2) ? EMIT_A : EMIT_B;
        end
    end

    assign final_bit   = (state_q == EMIT_B) || ((state_q == EMIT_A) && !keep_b_q);
    assign in_ready_o  = (state_q == LOAD);
    assign out_valid_o = (state_q == EMIT_A) || (state_q == EMIT_B);
    assign out_bit_o   = (state_q == EMIT_A) ? a_q : ((state_q == EMIT_B) ? b_q : 1'b0);
    assign out_last_o  = final_bit && (tail_q == 3'd6);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Randomized bench for conv_encoder_punct against an index-based encoder/puncture model.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_i;
    logic [1:0] rate_i;
    logic       in_valid_i, in_bit_i, in_last_i, out_ready_i;
    logic       in_ready_o, out_valid_o, out_bit_o, out_last_o, busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    bit din[$];
    bit enc_q[$];
    bit exp_q[$];
    bit rx[$];
    int last_idx, n_last, stall_err, overlap_err, lat_err, busy_cyc;
    bit timeout, ready_after_start, busy_low_after;

    always #5 clk = ~clk;

    conv_encoder_punct dut (
        .clock1_i    (clk),
        .reset_n_i   (reset_n),
        .start_i     (start_i),
        .rate_i      (rate_i),
        .in_valid_i  (in_valid_i),
        .in_bit_i    (in_bit_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_bit_o   (out_bit_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    function automatic bit tap(input int i);
        return (i >= 0) ? enc_q[i] : 1'b0;
    endfunction

    // Encoded-bit n uses bits n-1..n-6 as its history; phase is n mod period.
    function automatic void model(input int rate);
        int per, ph;
        bit a, b;
        exp_q.delete();
        enc_q = din;
        repeat (6) enc_q.push_back(1'b0);
        per = (rate == 1) ? 2 : ((rate == 2) ? 3 : 1);
        for (int n = 0; n < enc_q.size(); n++) begin
            a  = enc_q[n] ^ tap(n-2) ^ tap(n-3) ^ tap(n-5) ^ tap(n-6);
            b  = enc_q[n] ^ tap(n-1) ^ tap(n-2) ^ tap(n-3) ^ tap(n-6);
            ph = n % per;
            if (ph != 2) exp_q.push_back(a);
            if (ph != 1) exp_q.push_back(b);
        end
    endfunction

    function automatic int first_diff();
        if (rx.size() != exp_q.size()) return -2;
        for (int i = 0; i < rx.size(); i++)
            if (rx[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Called and returns at a negedge. Drives one frame and records what came out.
    task automatic run_frame(input int rate, input int gap_pct, input int stall_pct,
                             input int abort_after, input bit stray_start);
        int  idx, cyc;
        bit  prev_stall, prev_bit, prev_last, prev_acc, saw_last;
        rx.delete();
        last_idx = -1; n_last = 0; stall_err = 0; overlap_err = 0; lat_err = 0;
        busy_cyc = 0; timeout = 0; busy_low_after = 0;
        start_i = 1'b1; rate_i = 2'(rate); in_valid_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        ready_after_start = in_ready_o;
        idx = 0; cyc = 0; prev_stall = 0; prev_bit = 0; prev_last = 0; prev_acc = 0; saw_last = 0;
        forever begin
            if (saw_last) begin
                busy_low_after = (busy_o === 1'b0);
                break;
            end
            if (abort_after >= 0 && rx.size() >= abort_after) break;
            if (cyc > 3000) begin
                timeout = 1'b1;
                break;
            end
            if (busy_o) busy_cyc++;
            if (in_ready_o && out_valid_o) overlap_err++;
            if (prev_stall && (out_valid_o !== 1'b1 || out_bit_o !== prev_bit || out_last_o !== prev_last))
                stall_err++;
            if (prev_acc && out_valid_o !== 1'b1) lat_err++;

            start_i     = stray_start && (cyc == 3);
            rate_i      = stray_start ? 2'd2 : 2'($urandom_range(3));
            in_valid_i  = (idx < din.size()) && ($urandom_range(99) >= gap_pct);
            in_bit_i    = in_valid_i ? din[idx] : ($urandom_range(1) == 1);
            in_last_i   = in_valid_i ? (idx == din.size() - 1) : ($urandom_range(1) == 1);
            out_ready_i = ($urandom_range(99) >= stall_pct);

            prev_acc = in_valid_i && in_ready_o;
            if (prev_acc) idx++;
            prev_stall = out_valid_o && !out_ready_i;
            prev_bit   = out_bit_o;
            prev_last  = out_last_o;
            if (out_valid_o && out_ready_i) begin
                rx.push_back(out_bit_o);
                if (out_last_o) begin
                    n_last++;
                    last_idx = rx.size() - 1;
                    saw_last = 1'b1;
                end
            end
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start_i = 1'b1; rate_i = 2'd2; in_valid_i = 1'b1;
        in_bit_i = 1'b1; in_last_i = 1'b1; out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready_o, out_valid_o, out_bit_o, out_last_o, busy_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000", {in_ready_o, out_valid_o, out_bit_o, out_last_o, busy_o});
        end
        reset_n = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_impulse;
        logic [13:0] imp_ref;
        int diffs;
        imp_ref = 14'b11011111001011;
        din.delete(); din.push_back(1'b1);
        model(0);
        run_frame(0, 0, 0, -1, 0);
        diffs = 0;
        for (int i = 0; i < 14 && i < rx.size(); i++) if (rx[i] !== imp_ref[13-i]) diffs++;
        n_cmp++;
        if (timeout || rx.size() != 14 || diffs != 0) begin
            n_fail++;
            $display("FAIL impulse_seq: got %0d bits (%0d wrong, timeout=%0b) required 14 listed bits", rx.size(), diffs, timeout);
        end
        n_cmp++;
        if (first_diff() != -1) begin
            n_fail++;
            $display("FAIL impulse_model: first diff %0d required -1", first_diff());
        end
        n_cmp++;
        if (last_idx != 13 || n_last != 1) begin
            n_fail++;
            $display("FAIL impulse_last: at %0d count %0d required at 13 count 1", last_idx, n_last);
        end
        n_cmp++;
        if (!busy_low_after || !ready_after_start) begin
            n_fail++;
            $display("FAIL impulse_handshake: busy_low_after=%0b ready_after_start=%0b required 1 1", busy_low_after, ready_after_start);
        end
        n_cmp++;
        if (busy_cyc != 15 || lat_err != 0) begin
            n_fail++;
            $display("FAIL impulse_throughput: busy cycles %0d latency errs %0d required 15 0", busy_cyc, lat_err);
        end
    endtask

    task automatic test_all_ones;
        logic [5:0] head;
        head = 6'b111001;
        din.delete(); repeat (3) din.push_back(1'b1);
        model(0);
        run_frame(0, 0, 0, -1, 0);
        n_cmp++;
        if (rx.size() != 18 || {rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]} !== head) begin
            n_fail++;
            $display("FAIL ones_head: got %0d bits required 18 starting 111001", rx.size());
        end
        n_cmp++;
        if (first_diff() != -1 || last_idx != 17 || busy_cyc != 21) begin
            n_fail++;
            $display("FAIL ones_model: diff %0d last %0d busy %0d required -1 17 21", first_diff(), last_idx, busy_cyc);
        end
    endtask

    task automatic test_rate34;
        din.delete(); repeat (3) din.push_back(1'b1);
        model(2);
        run_frame(2, 0, 0, -1, 0);
        n_cmp++;
        if (rx.size() != 12 || {rx[0], rx[1], rx[2], rx[3]} !== 4'b1111 || last_idx != 11) begin
            n_fail++;
            $display("FAIL rate34: got %0d bits last %0d required 12 bits 1111.. last 11", rx.size(), last_idx);
        end
        n_cmp++;
        if (first_diff() != -1) begin
            n_fail++;
            $display("FAIL rate34_model: first diff %0d required -1", first_diff());
        end
    endtask

    task automatic test_rate23;
        int ones;
        din.delete(); din.push_back(1'b0); din.push_back(1'b0);
        model(1);
        run_frame(1, 0, 0, -1, 0);
        ones = 0;
        foreach (rx[i]) if (rx[i]) ones++;
        n_cmp++;
        if (rx.size() != 12 || ones != 0 || last_idx != 11) begin
            n_fail++;
            $display("FAIL rate23: got %0d bits %0d ones last %0d required 12 0 11", rx.size(), ones, last_idx);
        end
    endtask

    task automatic test_back_to_back;
        din.delete(); din.push_back(1'b1); din.push_back(1'b0); din.push_back(1'b1);
        model(1);
        run_frame(1, 0, 0, -1, 0);
        n_cmp++;
        if (!ready_after_start || first_diff() != -1 || last_idx != exp_q.size() - 1) begin
            n_fail++;
            $display("FAIL back_to_back: ready %0b diff %0d last %0d required 1 -1 %0d", ready_after_start, first_diff(), last_idx, exp_q.size() - 1);
        end
    endtask

    task automatic test_backpressure;
        din.delete(); din.push_back(1'b1);
        model(0);
        run_frame(0, 0, 50, -1, 0);
        n_cmp++;
        if (timeout || first_diff() != -1 || last_idx != 13) begin
            n_fail++;
            $display("FAIL bp_seq: diff %0d last %0d timeout %0b required -1 13 0", first_diff(), last_idx, timeout);
        end
        n_cmp++;
        if (stall_err != 0 || overlap_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable: stall errs %0d overlap %0d required 0 0", stall_err, overlap_err);
        end
    endtask

    task automatic test_start_ignored;
        din.delete(); din.push_back(1'b1);
        model(0);
        run_frame(0, 0, 0, -1, 1);
        n_cmp++;
        if (first_diff() != -1 || last_idx != 13) begin
            n_fail++;
            $display("FAIL start_ignored: diff %0d last %0d required -1 13", first_diff(), last_idx);
        end
    endtask

    task automatic test_reset_midframe;
        din.delete(); din.push_back(1'b1);
        model(0);
        run_frame(0, 0, 0, 5, 0);
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rx.size() != 5 || n_last != 0 ||
            {in_ready_o, out_valid_o, out_bit_o, out_last_o, busy_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: %0d bits %0d lasts outs %b required 5 0 00000", rx.size(), n_last,
                     {in_ready_o, out_valid_o, out_bit_o, out_last_o, busy_o});
        end
        reset_n = 1'b1;
        @(negedge clk);
        run_frame(0, 0, 0, -1, 0);
        n_cmp++;
        if (first_diff() != -1 || last_idx != 13) begin
            n_fail++;
            $display("FAIL reset_recover: diff %0d last %0d required -1 13", first_diff(), last_idx);
        end
    endtask

    task automatic test_random;
        int rate, len;
        for (int f = 0; f < 8; f++) begin
            rate = $urandom_range(3);
            len  = $urandom_range(20, 1);
            din.delete();
            repeat (len) din.push_back($urandom_range(1) == 1);
            model(rate);
            run_frame(rate, 30, 40, -1, 0);
            n_cmp++;
            if (timeout || first_diff() != -1 || last_idx != exp_q.size() - 1 || n_last != 1 ||
                stall_err != 0 || overlap_err != 0 || lat_err != 0 || !busy_low_after) begin
                n_fail++;
                $display("FAIL random_frame%0d: rate %0d len %0d diff %0d last %0d/%0d errs %0d/%0d/%0d required match", f, rate, len,
                         first_diff(), last_idx, exp_q.size() - 1, stall_err, overlap_err, lat_err);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start_i = 1'b0; rate_i = 2'd0; in_valid_i = 1'b0;
        in_bit_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk);
        test_reset;
        test_impulse;
        test_all_ones;
        test_rate34;
        test_rate23;
        test_back_to_back;
        test_backpressure;
        test_start_ignored;
        test_reset_midframe;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
# conv_encoder_punct

Transmit-side channel encoder for the WiFi PHY: the K=7 convolutional encoder (generators 133/171 octal) with IEEE 802.11a puncturing at rates 1/2, 2/3 and 3/4. Its output stream is the one the receive-side Viterbi decoder and its path-metric memory consume. It sits between the TX scrambler and the interleaver. Uncoded bits come in one per handshake, and coded bits go out serially one per handshake. Six zero tail bits are appended automatically after the last data bit.

## Interface
- No parameters. K=7, generators and puncture patterns are fixed.
- Clock1  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- Rate  in  2  0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 1/2; sampled only on an honoured Start.
- InValid  in  1  an input bit is present.
- InBit  in  1  uncoded data bit.
- InLast  in  1  marks the last data bit of the frame; qualified by InValid.
- InReady  out  1  encoder accepts an input bit this cycle.
- OutValid  out  1  OutBit is valid.
- OutBit  out  1  coded bit.
- OutLast  out  1  last coded bit of the frame; qualified by OutValid.
- OutReady  in  1  downstream takes OutBit this cycle.
- Busy  out  1  frame in progress (state != IDLE).

## Operation
- Shift register d[6:1]: d1 is the newest previous bit.
- Per encoded bit b (data or tail): A = b^d2^d3^d5^d6, B = b^d1^d2^d3^d6. Then d <= {d[5:1], b}.
- Puncture phase p counts encoded bits modulo the period and wraps after the last phase. Period is 1 for rate 1/2, 2 for rate 2/3, 3 for rate 3/4.
- Kept bits per phase, emitted A before B:
  - Rate 1/2: A,B.
  - Rate 2/3: p0 A,B; p1 A.
  - Rate 3/4: p0 A,B; p1 A; p2 B.
- States:
  - IDLE: an honoured Start latches Rate, clears d, p, tail counter and last flag, then goes to LOAD.
  - LOAD: InReady=1. On InValid&InReady, encode InBit, register A and B plus the keep mask, and set the last flag if InLast. Go to EMIT_A if A is kept, otherwise EMIT_B.
  - EMIT_A: OutValid=1, OutBit=A. On OutReady, go to EMIT_B if B is kept, otherwise to NEXT.
  - EMIT_B: OutValid=1, OutBit=B. On OutReady, go to NEXT.
  - NEXT: this is a decision point, taken in the same cycle as the final output transfer (no bubble cycle).
    - Last flag clear: go to LOAD.
    - Last flag set and tail counter < 6: encode a zero bit internally, increment the tail counter, and go to EMIT_A or EMIT_B.
    - Tail counter == 6: go to IDLE.
- OutLast=1 only on the final kept bit of the 6th tail bit.
- Puncture phase continues across the data/tail boundary; it is not reset at the tail.
- Start outside IDLE is ignored. InValid outside LOAD is ignored, and no bit is consumed.
- Rate changes mid-frame have no effect until the next Start.
- OutBit and OutLast must stay stable while OutValid=1 and OutReady=0.

## Timing
- Reset values: InReady=0, OutValid=0, OutBit=0, OutLast=0, Busy=0, state IDLE, d=0, p=0.
- Reset asserted mid-frame: on the next edge, return to reset values and drop any partially emitted bits. No OutLast is produced.
- Start at edge t gives InReady=1 from cycle t+1.
- Input accepted at edge t gives the first kept bit with OutValid=1 in cycle t+1. InReady=0 until the last kept bit of that input bit transfers.
- Throughput: 1 input bit per (1 + kept bits) cycles with OutReady held high.
- Tail bits need no input handshake. Each is encoded at the output transfer that ends the previous bit.
- After the OutLast transfer, Busy=0 in the next cycle. A new Start is accepted in that cycle.

## Test plan
- Impulse, rate 1/2: Start, Rate=0; single bit 1 with InLast.
  - Required: 14 coded bits 1,1,0,1,1,1,1,1,0,0,1,0,1,1.
  - OutLast on the 14th bit; Busy falls the next cycle.
- All-ones, rate 1/2: inputs 1,1,1 (last on the third).
  - Required: first six coded bits 1,1,1,0,0,1.
  - 18 bits total.
- Rate 3/4: inputs 1,1,1 with InLast on the third.
  - Required: 9 encoded bits gives 12 coded bits, first four 1,1,1,1.
  - OutLast on the 12th.
- Rate 2/3: 2 data bits 0,0.
  - Required: 12 coded bits, all 0, OutLast on the 12th.
  - p returns to 0 at the end.
- Backpressure: the impulse test with OutReady toggling randomly.
  - Required: identical bit sequence.
  - OutBit stable while stalled.
  - InReady never high while OutValid is high.
- Reset mid-frame and Start ignored: assert Reset after 5 coded bits.
  - Required: all outputs 0 next cycle, then a new frame reproduces the impulse sequence.
  - A Start pulse while Busy=1 does not change Rate or outputs.
